// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch requester, load/store requester,
// shared memory port and status. The slave modport is the arbiter's view;
// the master modport is the requesters/memory side driving it.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        owner;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output busy, owner
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch + load/store) in front of a single
// memory port. One transaction at a time: IDLE grants, BUSY holds the latched
// request until mem_ready or a wait-cycle timeout.
// Optional macro MEM_ARB_RR_EN: resolve simultaneous requests round-robin
// instead of the default fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        owner;
  logic [7:0]  wait_cnt;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        if_rvalid_q;
  logic        d_rvalid_q;
  logic        if_err_q;
  logic        d_err_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic        grant_if;
  logic        grant_d;
  logic        tie_to_d;
  logic        done_ok;
  logic        done_abort;

`ifdef MEM_ARB_RR_EN
  logic last_winner;

  // Remember who won the latest grant (1 = data) so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_winner <= 1'b1;
    end else if (grant_if || grant_d) begin
      last_winner <= grant_d;
    end
  end

  assign tie_to_d = ~last_winner;
`else
  assign tie_to_d = 1'b1;
`endif

  // State register for the IDLE/BUSY controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection in IDLE, completion/timeout detection in BUSY; grants are forced off in reset.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (bus.d_req && (!bus.if_req || tie_to_d)) begin
            grant_d = 1'b1;
          end else if (bus.if_req) begin
            grant_if = 1'b1;
          end
          if (grant_if || grant_d) begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          done_abort = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the granted request, count wait cycles, and produce the one-cycle response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      wait_cnt    <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if (grant_d) begin
        owner       <= 1'b1;
        wait_cnt    <= 8'd0;
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        mem_wstrb_q <= bus.d_wstrb;
      end else if (grant_if) begin
        owner       <= 1'b0;
        wait_cnt    <= 8'd0;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= 32'd0;
        mem_wstrb_q <= 4'd0;
      end else if (state == BUSY) begin
        if (done_ok || done_abort) begin
          if (owner) begin
            d_rvalid_q <= 1'b1;
            d_err_q    <= done_abort;
            d_rdata_q  <= (done_abort || mem_we_q) ? 32'd0 : bus.mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_err_q    <= done_abort;
            if_rdata_q  <= done_abort ? 32'd0 : bus.mem_rdata;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.mem_req   = (state == BUSY);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.busy      = (state == BUSY);
  assign bus.owner     = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 4).
// Tie expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  bit   rr_mode;
  bit   exp_d;
  bit   prev_d;

  mem_arbiter_if bus();

  mem_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      passed++;
    end
  endtask

  task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                               input logic d_req, input logic d_we, input logic [31:0] d_addr,
                               input logic [31:0] d_wdata, input logic [3:0] d_wstrb,
                               input logic mem_ready, input logic [31:0] mem_rdata);
    bus.if_req    = if_req;
    bus.if_addr   = if_addr;
    bus.d_req     = d_req;
    bus.d_we      = d_we;
    bus.d_addr    = d_addr;
    bus.d_wdata   = d_wdata;
    bus.d_wstrb   = d_wstrb;
    bus.mem_ready = mem_ready;
    bus.mem_rdata = mem_rdata;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, tie arbitration, fetch, store, timeout, reset mid-transaction.
  initial begin
    checks = 0;
    passed = 0;
`ifdef MEM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    nextCycle();
    nextCycle();

    $display("[TB] reset state");
    applyStimulus(1'b1, 32'h111, 1'b1, 1'b1, 32'h222, 32'h333, 4'h5, 1'b1, 32'h444);
    checkOutput("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_owner", 32'(bus.owner), 32'd0);
    checkOutput("rst_rvalids", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);

    $display("[TB] tie arbitration");
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_d = rr_mode ? (t % 2 == 1) : 1'b1;
      applyStimulus(1'b1, 32'h1000 + 32'(t), 1'b1, 1'b0, 32'h2000 + 32'(t), 32'd0, 4'd0, 1'b0, 32'd0);
      checkOutput("tie_d_gnt", 32'(bus.d_gnt), 32'(exp_d));
      checkOutput("tie_if_gnt", 32'(bus.if_gnt), 32'(!exp_d));
      if (t > 0) begin
        checkOutput("tie_prev_d_rvalid", 32'(bus.d_rvalid), 32'(prev_d));
        checkOutput("tie_prev_if_rvalid", 32'(bus.if_rvalid), 32'(!prev_d));
        checkOutput("tie_prev_rdata", prev_d ? bus.d_rdata : bus.if_rdata, 32'hA0 + 32'(t - 1));
      end
      nextCycle();
      applyStimulus(1'b1, 32'h1000 + 32'(t), 1'b1, 1'b0, 32'h2000 + 32'(t), 32'd0, 4'd0, 1'b1, 32'hA0 + 32'(t));
      checkOutput("tie_owner", 32'(bus.owner), 32'(exp_d));
      checkOutput("tie_mem_addr", bus.mem_addr, exp_d ? 32'h2000 + 32'(t) : 32'h1000 + 32'(t));
      prev_d = exp_d;
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("tie_last_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    checkOutput("tie_last_rdata", bus.d_rdata, 32'hA3);
    nextCycle();

    $display("[TB] fetch only");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("fetch_if_gnt", 32'(bus.if_gnt), 32'd1);
    checkOutput("fetch_d_gnt", 32'(bus.d_gnt), 32'd0);
    checkOutput("fetch_mem_req_n", 32'(bus.mem_req), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h999, 32'h1, 4'h1, 1'b1, 32'h00000013);
    checkOutput("fetch_mem_req", 32'(bus.mem_req), 32'd1);
    checkOutput("fetch_mem_addr", bus.mem_addr, 32'h100);
    checkOutput("fetch_mem_we_wstrb", 32'({bus.mem_we, bus.mem_wstrb}), 32'd0);
    checkOutput("fetch_busy_owner", 32'({bus.busy, bus.owner}), 32'b10);
    checkOutput("fetch_busy_d_gnt", 32'(bus.d_gnt), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("fetch_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    checkOutput("fetch_if_rdata", bus.if_rdata, 32'h00000013);
    checkOutput("fetch_if_err", 32'(bus.if_err), 32'd0);
    checkOutput("fetch_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    checkOutput("fetch_done_idle", 32'({bus.busy, bus.mem_req}), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("idle_ready_ignored", 32'({bus.busy, bus.if_rvalid, bus.d_rvalid}), 32'd0);

    $display("[TB] store with wait cycles");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0);
    checkOutput("store_d_gnt", 32'(bus.d_gnt), 32'd1);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h5555, 32'h1234, 4'h3, (k == 3), 32'h7777_7777);
      checkOutput("store_mem_req", 32'(bus.mem_req), 32'd1);
      checkOutput("store_mem_addr", bus.mem_addr, 32'h2004);
      checkOutput("store_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      checkOutput("store_mem_we_wstrb", 32'({bus.mem_we, bus.mem_wstrb}), 32'h1F);
      checkOutput("store_held_off", 32'({bus.if_gnt, bus.d_rvalid}), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("store_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    checkOutput("store_d_err", 32'(bus.d_err), 32'd0);
    checkOutput("store_d_rdata", bus.d_rdata, 32'd0);
    checkOutput("store_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    checkOutput("store_regrant_if", 32'(bus.if_gnt), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hCAFE0001);
    checkOutput("regrant_mem_addr", bus.mem_addr, 32'h200);
    checkOutput("regrant_owner", 32'(bus.owner), 32'd0);
    checkOutput("regrant_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("regrant_if_rdata", bus.if_rdata, 32'hCAFE0001);
    nextCycle();

    $display("[TB] timeout");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'd0, 4'd0, 1'b0, 32'h55AA55AA);
    checkOutput("to_d_gnt", 32'(bus.d_gnt), 32'd1);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'h55AA55AA);
      checkOutput("to_mem_req", 32'(bus.mem_req), 32'd1);
      checkOutput("to_no_rvalid", 32'(bus.d_rvalid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("to_mem_req_low", 32'(bus.mem_req), 32'd0);
    checkOutput("to_busy", 32'(bus.busy), 32'd0);
    checkOutput("to_d_rvalid_err", 32'({bus.d_rvalid, bus.d_err}), 32'b11);
    checkOutput("to_d_rdata", bus.d_rdata, 32'd0);
    checkOutput("to_if_side", 32'({bus.if_rvalid, bus.if_err}), 32'd0);
    nextCycle();
    checkOutput("to_err_pulse", 32'({bus.d_rvalid, bus.d_err}), 32'd0);

    $display("[TB] reset during busy");
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("rb_if_gnt", 32'(bus.if_gnt), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h99);
    checkOutput("rb_busy2", 32'(bus.busy), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("rb_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rb_busy", 32'(bus.busy), 32'd0);
    checkOutput("rb_no_rvalid", 32'({bus.if_rvalid, bus.if_err}), 32'd0);
    checkOutput("rb_gnt_in_reset", 32'(bus.if_gnt), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rb_fresh_gnt", 32'(bus.if_gnt), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h77);
    checkOutput("rb_fresh_addr", bus.mem_addr, 32'h500);
    checkOutput("rb_fresh_req", 32'(bus.mem_req), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    checkOutput("rb_fresh_rvalid", 32'(bus.if_rvalid), 32'd1);
    checkOutput("rb_fresh_rdata", bus.if_rdata, 32'h77);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles without mem_ready before abort (range 2..255).
REQ-002 SHALL have ports: clk in 1, the single clock; rst_n in 1, synchronous active-low reset.
REQ-003 SHALL have ports: if_req in 1, if_addr in 32, if_gnt out 1, if_rvalid out 1, if_rdata out 32, if_err out 1 (instruction-fetch requester, read-only).
REQ-004 SHALL have ports: d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_wstrb in 4, d_gnt out 1, d_rvalid out 1, d_rdata out 32, d_err out 1 (load/store requester).
REQ-005 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4, mem_ready in 1, mem_rdata in 32 (single shared memory port).
REQ-006 SHALL have ports: busy out 1, high when not IDLE; owner out 1, 0 = fetch and 1 = data, valid while busy.

Function
REQ-007 SHALL implement FSM states IDLE and BUSY, with a registered owner bit.
REQ-008 In IDLE with at least one request, SHALL assert exactly one gnt combinationally in that cycle (N), latch that requester's addr/we/wdata/wstrb, and enter BUSY at edge N+1.
REQ-009 Fetch transactions SHALL drive mem_we=0 and mem_wstrb=0.
REQ-010 Fixed priority (macro absent): when if_req and d_req are both high in IDLE, d_gnt wins.
REQ-011 In BUSY, mem_req SHALL be 1 and mem_* SHALL hold the latched values, stable until completion.
REQ-012 mem_ready sampled high in BUSY SHALL complete the transaction: next cycle, the owner's rvalid pulses for 1 cycle with rdata = registered mem_rdata; writes also pulse rvalid, with rdata undefined-but-zero.
REQ-013 FSM SHALL return to IDLE on the completion edge; a new gnt is allowed in the same cycle as the rvalid pulse (minimum 2 cycles between grants).
REQ-014 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle with mem_ready low.
REQ-015 When the counter reaches TIMEOUT_CYCLES-1 with mem_ready low, SHALL abort: mem_req low next cycle; owner's rvalid and err pulse together for 1 cycle; rdata = 0; return to IDLE.
REQ-016 mem_ready in the same cycle as the timeout threshold SHALL count as normal completion (err=0).
REQ-017 mem_ready while IDLE SHALL be ignored.
REQ-018 In BUSY, gnt outputs SHALL be 0; requests are held off and not latched.
REQ-019 Requesters SHALL keep req high until gnt; a req dropped before gnt is simply not served.
REQ-020 The non-owner's rvalid and err SHALL be 0 at all times.

Reset
REQ-021 On rst_n=0 at a clk edge, SHALL enter IDLE and set to 0: counter, owner, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, both rvalid, both rdata, both err, busy.
REQ-022 Reset during BUSY SHALL abandon the transaction with no rvalid/err pulse; gnt outputs SHALL be 0 while rst_n=0.
REQ-023 The round-robin last-winner register SHALL reset to data (1), so the first tie goes to fetch.

Configuration
REQ-024 Macro MEM_ARB_RR_EN, defined: ties SHALL be resolved round-robin, granting the requester not granted most recently; last-winner updates on every grant.
REQ-025 MEM_ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-010; no last-winner register is present.

Verification
REQ-026 Fetch only: if_req, if_addr=0x100, mem_ready=1 at the first BUSY cycle, mem_rdata=0x00000013 -> if_gnt at N, mem_req at N+1, if_rvalid at N+2 with if_rdata=0x00000013, if_err=0.
REQ-027 Store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=0xF, 3 wait cycles -> mem_* stable for 4 cycles, then d_rvalid pulse, if_rvalid=0.
REQ-028 Tie, both requests held for 4 transactions -> macro absent: D,D,D,D; MEM_ARB_RR_EN: I,D,I,D.
REQ-029 Timeout, TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high 4 cycles, then d_rvalid=d_err=1, d_rdata=0, busy=0.
REQ-030 rst_n=0 in the 2nd BUSY cycle of a fetch -> next cycle mem_req=0, busy=0, no if_rvalid; a fresh if_req after release is granted normally.
